// File: rtl/alu_operand_stage.sv
// ALU operand stage: selects A/B from packed sources, forwards EX/MEM writebacks,
// stalls on load-use hazards and registers the operand pair behind a valid/ready skid-free stage.
module alu_operand_stage #(
   parameter int                   DATA_W   = 16,
   parameter int                   NUM_SRC  = 4,
   parameter int                   SEL_W    = 2,
   parameter int                   REG_W    = 4,
   parameter int                   CNT_W    = 8,
   parameter logic [NUM_SRC-1:0]   FWD_MASK = 4'b1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [SEL_W-1:0]          sel_a,
   input  logic [SEL_W-1:0]          sel_b,
   input  logic [REG_W-1:0]          idx_a,
   input  logic [REG_W-1:0]          idx_b,
   input  logic                      ex_wr_en,
   input  logic [REG_W-1:0]          ex_wr_idx,
   input  logic [DATA_W-1:0]         ex_wr_data,
   input  logic                      ex_is_load,
   input  logic                      mem_wr_en,
   input  logic [REG_W-1:0]          mem_wr_idx,
   input  logic [DATA_W-1:0]         mem_wr_data,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_a,
   output logic [DATA_W-1:0]         out_b,
   output logic [CNT_W-1:0]          stall_cnt
);

   // Out-of-range selects fall through both loops: zero data, never forwardable.
   function automatic logic [DATA_W-1:0] raw_src(input logic [SEL_W-1:0] sel,
                                                 input logic [NUM_SRC*DATA_W-1:0] src);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (int'(sel) == i) r = src[i*DATA_W +: DATA_W];
      return r;
   endfunction

   function automatic logic fwd_ok(input logic [SEL_W-1:0] sel);
      logic f;
      f = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         if (int'(sel) == i) f = FWD_MASK[i];
      return f;
   endfunction

   logic              fwd_a, fwd_b, a_ex, b_ex, a_mem, b_mem;
   logic [DATA_W-1:0] opnd_a, opnd_b;
   logic              hazard, capture;

   logic              out_valid_d, out_valid_q;
   logic [DATA_W-1:0] out_a_d, out_a_q, out_b_d, out_b_q;
   logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

   always_comb begin
      fwd_a  = fwd_ok(sel_a);
      fwd_b  = fwd_ok(sel_b);
      a_ex   = fwd_a && ex_wr_en  && (ex_wr_idx  == idx_a);
      b_ex   = fwd_b && ex_wr_en  && (ex_wr_idx  == idx_b);
      a_mem  = fwd_a && mem_wr_en && (mem_wr_idx == idx_a);
      b_mem  = fwd_b && mem_wr_en && (mem_wr_idx == idx_b);
      opnd_a = a_ex ? ex_wr_data : (a_mem ? mem_wr_data : raw_src(sel_a, src_data));
      opnd_b = b_ex ? ex_wr_data : (b_mem ? mem_wr_data : raw_src(sel_b, src_data));
      // A load in EX has no data yet, so forwarding from it must wait a cycle.
      hazard   = in_valid && ex_is_load && (a_ex || b_ex);
      in_ready = (!out_valid_q || out_ready) && !hazard;
      capture  = in_valid && in_ready && !flush;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      stall_cnt_d = stall_cnt_q;
      if (flush)          out_valid_d = 1'b0;
      else if (capture)   out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
      if (capture) begin
         out_a_d = opnd_a;
         out_b_d = opnd_b;
      end
      if (hazard && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected pairs queued at issue, monitor pops on transfer.
module tb_alu_operand_stage;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_ready2;
   logic [4*DW-1:0] src_data;
   logic [1:0]    sel_a, sel_b;
   logic [3:0]    idx_a, idx_b;
   logic          ex_wr_en, ex_is_load, mem_wr_en, flush, out_ready;
   logic [3:0]    ex_wr_idx, mem_wr_idx;
   logic [DW-1:0] ex_wr_data, mem_wr_data;
   logic          out_valid, out_valid2;
   logic [DW-1:0] out_a, out_b, out_a2, out_b2;
   logic [7:0]    stall_cnt;
   logic [1:0]    stall_cnt2;

   int n_chk  = 0;
   int n_fail = 0;
   logic [2*DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   alu_operand_stage u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .src_data(src_data),
      .sel_a(sel_a), .sel_b(sel_b), .idx_a(idx_a), .idx_b(idx_b),
      .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
      .mem_wr_en(mem_wr_en), .mem_wr_idx(mem_wr_idx), .mem_wr_data(mem_wr_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .stall_cnt(stall_cnt)
   );

   // Narrow-counter copy on the same stimulus, used only for saturation and reset of stall_cnt.
   alu_operand_stage #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .src_data(src_data),
      .sel_a(sel_a), .sel_b(sel_b), .idx_a(idx_a), .idx_b(idx_b),
      .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
      .mem_wr_en(mem_wr_en), .mem_wr_idx(mem_wr_idx), .mem_wr_data(mem_wr_data), .flush(flush),
      .out_valid(out_valid2), .out_ready(out_ready), .out_a(out_a2), .out_b(out_b2), .stall_cnt(stall_cnt2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [1:0] sa, input logic [1:0] sb, input logic [DW-1:0] ea,
                        input logic [DW-1:0] eb);
      in_valid = 1'b1; sel_a = sa; sel_b = sb;
      exp_q.push_back({ea, eb});
   endtask

   // Monitor: a pair is consumed on any cycle that shows out_valid && out_ready.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", {out_a, out_b}, 32'hxxxx_xxxx);
            else check("pair", {out_a, out_b}, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; sel_a = '0; sel_b = '0; idx_a = '0; idx_b = '0;
      ex_wr_en = 1'b0; ex_wr_idx = '0; ex_wr_data = '0; ex_is_load = 1'b0;
      mem_wr_en = 1'b0; mem_wr_idx = '0; mem_wr_data = '0; flush = 1'b0; out_ready = 1'b1;
      src_data = {16'h3333, 16'h2222, 16'h5555, 16'h1111};
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_a", 32'(out_a), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Plain selection, back-to-back, then forwarding priority.
      issue(2'd0, 2'd2, 16'h1111, 16'h2222); tick();
      issue(2'd1, 2'd0, 16'h5555, 16'h1111); tick();
      idx_a = 4'd5; ex_wr_en = 1'b1; ex_wr_idx = 4'd5; ex_wr_data = 16'hAAAA;
      mem_wr_en = 1'b1; mem_wr_idx = 4'd5; mem_wr_data = 16'hBBBB;
      issue(2'd3, 2'd2, 16'hAAAA, 16'h2222); tick();
      ex_wr_en = 1'b0;
      issue(2'd3, 2'd2, 16'hBBBB, 16'h2222); tick();
      // Source 0 is not forwardable even on an index match; source 3 on B is.
      mem_wr_en = 1'b0; ex_wr_en = 1'b1; idx_b = 4'd5;
      issue(2'd0, 2'd3, 16'h1111, 16'hAAAA); tick();
      in_valid = 1'b0; ex_wr_en = 1'b0; tick(); tick();

      // Load-use hazard on B: two stall cycles, then three more to saturate the 2-bit copy.
      in_valid = 1'b1; sel_a = 2'd0; sel_b = 2'd3; idx_b = 4'd7;
      ex_wr_en = 1'b1; ex_wr_idx = 4'd7; ex_is_load = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); check("hazard_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      check("stall_cnt_2", 32'(stall_cnt), 32'd2);
      for (int i = 0; i < 3; i++) tick();
      check("stall_cnt_5", 32'(stall_cnt), 32'd5);
      check("stall_cnt_sat", 32'(stall_cnt2), 32'd3);
      in_valid = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0; tick();

      // Backpressure: held pair stays stable, new input refused.
      out_ready = 1'b0;
      issue(2'd0, 2'd2, 16'h1111, 16'h2222); tick();
      sel_a = 2'd1; sel_b = 2'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_pair", {out_a, out_b}, 32'h1111_2222);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1; tick(); tick();

      // Flush wins over a capture.
      in_valid = 1'b1; sel_a = 2'd1; sel_b = 2'd1; flush = 1'b1; tick();
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk); check("flush_out_valid", 32'(out_valid), 32'd0);
      tick();

      // Asynchronous reset mid-cycle drops a held pair and clears the counter.
      out_ready = 1'b0; in_valid = 1'b1; sel_a = 2'd0; sel_b = 2'd2; tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_pair", {out_a, out_b}, 32'd0);
      check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("arst_stall_cnt2", 32'(stall_cnt2), 32'd0);
      #1 rst = 1'b0;
      out_ready = 1'b1; tick(); tick();
      @(negedge clk); check("post_rst_idle", 32'(out_valid), 32'd0);
      tick();

      issue(2'd2, 2'd0, 16'h2222, 16'h1111); tick();
      in_valid = 1'b0; tick(); tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
